// File: rtl/i2s_tx_sequencer_if.sv
// Sample-source / codec-pin bundle for the I2S transmit sequencer.
// master = sample source side, slave = the sequencer itself.
interface i2s_tx_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              run;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic              busy;
    logic [7:0]        underrun_cnt;

    modport master (
        output run, left_data, right_data, sample_valid,
        input  sample_ready, bclk, lrclk, sdata, busy, underrun_cnt
    );

    modport slave (
        input  run, left_data, right_data, sample_valid,
        output sample_ready, bclk, lrclk, sdata, busy, underrun_cnt
    );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// Master-mode I2S transmitter: BCLK/LRCLK generation, one stereo pair per frame, MSB first.
// Optional build macro I2S_MUTE_ON_UNDERRUN_EN: underrun frames send zeros instead of repeating.
module i2s_tx_sequencer #(
    parameter int DATA_W    = 16,
    parameter int BCLK_HALF = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic                 clk_in,
    input  logic                 reset,
    i2s_tx_sequencer_if.slave    bus
);
    localparam int F_W = $clog2(2 * SLOT_BITS);
    localparam int D_W = $clog2(BCLK_HALF);

    localparam logic [D_W-1:0] DIV_LAST = D_W'(BCLK_HALF - 1);
    localparam logic [F_W-1:0] F_LAST   = F_W'(2 * SLOT_BITS - 1);
    localparam logic [F_W-1:0] SLOT_F   = F_W'(SLOT_BITS);
    localparam logic [F_W-1:0] DATA_F   = F_W'(DATA_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [D_W-1:0]    div_q, div_d;
    logic              bclk_q, bclk_d;
    logic [F_W-1:0]    f_q, f_d;
    logic [DATA_W-1:0] l_q, l_d, r_q, r_d;
    logic [7:0]        und_q, und_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    logic              boundary;
    logic              ready;
    logic [F_W-1:0]    slot_pos;
    logic [DATA_W-1:0] slot_word;
    logic [DATA_W-1:0] shifted;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bclk_q  <= 1'b0;
            f_q     <= '0;
            l_q     <= '0;
            r_q     <= '0;
            und_q   <= '0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            f_q     <= f_d;
            l_q     <= l_d;
            r_q     <= r_d;
            und_q   <= und_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bclk_d   = bclk_q;
        f_d      = f_q;
        l_d      = l_q;
        r_d      = r_q;
        und_d    = und_q;
        boundary = 1'b0;
        ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_d    = '0;
                bclk_d   = 1'b0;
                f_d      = '0;
                boundary = 1'b1;
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        if (f_q == F_LAST) begin
                            f_d      = '0;
                            boundary = 1'b1;
                        end else begin
                            f_d = f_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // run is only honoured here; a frame in progress always completes
        if (boundary) begin
            if (bus.run) begin
                state_d = RUN;
                ready   = 1'b1;
                if (bus.sample_valid) begin
                    l_d = bus.left_data;
                    r_d = bus.right_data;
                end else begin
                    if (und_q != 8'hFF)
                        und_d = und_q + 1'b1;
`ifdef I2S_MUTE_ON_UNDERRUN_EN
                    l_d = '0;
                    r_d = '0;
`else
                    l_d = l_q;
                    r_d = r_q;
`endif
                end
            end else begin
                state_d = IDLE;
            end
        end

        // Pin values are decoded from the next frame position so they land registered.
        slot_pos  = (f_d >= SLOT_F) ? (f_d - SLOT_F) : f_d;
        slot_word = (f_d >= SLOT_F) ? r_d : l_d;
        shifted   = slot_word << (slot_pos - 1'b1);
        lrclk_d   = (f_d >= SLOT_F);
        sdata_d   = ((slot_pos != '0) && (slot_pos <= DATA_F)) ? shifted[DATA_W-1] : 1'b0;
    end

    assign bus.sample_ready = ready & ~reset;
    assign bus.bclk         = bclk_q;
    assign bus.lrclk        = lrclk_q;
    assign bus.sdata        = sdata_q;
    assign bus.busy         = (state_q == RUN);
    assign bus.underrun_cnt = und_q;
endmodule

// File: doc/i2s_tx_sequencer.md
# i2s_tx_sequencer

- Master-mode I2S transmit controller clocked from the 50 MHz codec clock.
- Derives BCLK and LRCLK with its own divider counters and serialises one stereo sample pair per frame, MSB first, in standard I2S framing.
- Accepts samples through a frame-rate ready/valid handshake and counts underruns.
- Sits between the audio sample source and the codec's DACDAT/BCLK/DACLRCK pins.

## Interface
- DATA_W, 16: sample width per channel.
- BCLK_HALF, 8: clk_in cycles per BCLK half-period; must be ≥2. BCLK = 50 MHz / 16 = 3.125 MHz.
- SLOT_BITS, 32: BCLK periods per channel slot; must be ≥ DATA_W+1. Frame = 2·SLOT_BITS BCLKs.
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  enable. Sampled only in IDLE and at frame boundaries.
- left_data  in  DATA_W  left sample, two's complement.
- right_data  in  DATA_W  right sample.
- sample_valid  in  1  source holds a valid pair.
- sample_ready  out  1  transfer strobe. The pair is taken on the clk_in edge where sample_ready && sample_valid.
- bclk  out  1  bit clock.
- lrclk  out  1  0 = left slot, 1 = right slot.
- sdata  out  1  serial data. Changes only with bclk falling.
- busy  out  1  high whenever state is RUN.
- underrun_cnt  out  8  saturating count of frame boundaries with sample_valid low.

## Operation
- States: IDLE, RUN.
- Registers:
  - div_cnt (0..BCLK_HALF-1)
  - bclk
  - frame position f (0..2·SLOT_BITS-1)
  - shift words L, R
- In IDLE, bclk, lrclk, sdata and busy are held at 0, and f = 0.
- IDLE→RUN happens on the edge where run = 1. That edge is a frame boundary.
- In RUN:
  - div_cnt increments every cycle. When it reaches BCLK_HALF-1 it wraps to 0 and bclk toggles.
  - On each bclk falling toggle, f advances, wrapping at 2·SLOT_BITS-1→0.
- Outputs as a function of f:
  - lrclk = (f ≥ SLOT_BITS).
  - With slot position p = f mod SLOT_BITS: for p in 1..DATA_W, sdata = slot word bit [DATA_W-p]; otherwise sdata = 0.
  - The MSB therefore lags the LRCLK change by one BCLK, per the I2S standard.
- Frame boundary is the falling toggle that wraps f to 0, plus the IDLE→RUN edge:
  - If run = 1: sample_ready is high for that single cycle (combinational decode of registered state).
    - If sample_valid is also high, L/R load from the inputs.
    - Otherwise, underrun_cnt increments (saturating at 255) and the underrun data rule under Configuration applies.
  - If run = 0: there is no transfer. The state goes to IDLE on that edge and all outputs return to 0. A frame in progress is never truncated.
- sample_ready is 0 in every other cycle.
- If run toggles mid-frame and returns high before the boundary, the block continues seamlessly.
- Reset mid-frame: all registers clear immediately (asynchronous); outputs go to 0 and underrun_cnt goes to 0.

## Timing
- Let T be the edge entering RUN. There, bclk = 0, lrclk = 0, sdata = 0.
- bclk rises at T+BCLK_HALF and falls at T+2·BCLK_HALF, at which point sdata = L[DATA_W-1].
- Bit k of the left word (MSB = k 0) is valid from T+(k+1)·2·BCLK_HALF, lasting 2·BCLK_HALF cycles.
- lrclk rises at T+SLOT_BITS·2·BCLK_HALF.
- The next sample_ready occurs in the cycle before T+2·SLOT_BITS·2·BCLK_HALF. One frame is 1024 clk_in cycles at the defaults.
- Sample latency, input to first bit on the pin: 2·BCLK_HALF cycles.
- All outputs except sample_ready are registered.

## Configuration
- I2S_MUTE_ON_UNDERRUN_EN
  - Defined: on an underrun frame, L and R load with 0. The codec outputs silence.
  - Undefined: L and R retain the previous frame's words. The last sample repeats.
- underrun_cnt counts identically in both builds.

## Test plan
- Bench parameters: BCLK_HALF = 2, SLOT_BITS = 20, DATA_W = 16.
- Reset with run = 1 held, release reset, then valid pair L = 16'hA5C3, R = 16'h0F01:
  - sample_ready pulses once.
  - Capturing sdata on bclk rising gives 0, then A5C3 MSB-first, then three 0s.
  - Then lrclk = 1, followed by 0, then 0F01, then three 0s.
  - Frame length = 160 clk_in cycles.
- sample_valid low at the second boundary:
  - underrun_cnt = 1.
  - Frame 2 is all zeros with the macro defined, or a repeat of A5C3/0F01 without it.
- Drop run at f = 5:
  - The frame completes, with bits intact through f = 39.
  - At the boundary, state goes to IDLE, busy = 0, and bclk, lrclk, sdata = 0.
  - No sample_ready pulse.
- Assert reset at f = 12 of a frame: all outputs and underrun_cnt are 0 in the same cycle. Re-run restarts at f = 0 with a fresh transfer.
- Hold sample_valid low for 300 frames: underrun_cnt saturates at 255. A following valid pair loads normally.
